// File: rtl/output_channel_buffer_bank.sv
// output_channel_buffer_bank: per-channel output FIFOs with atomic multicast enqueue and valid/ready drain
module output_channel_buffer_bank #(
  parameter int TIA_NUM_OUTPUT_CHANNELS = 4,
  parameter int TIA_WORD_WIDTH = 32,
  parameter int TIA_TAG_WIDTH = 2,
  parameter int TIA_OUTPUT_CHANNEL_BUFFER_DEPTH = 2
) (
  input  logic                                               clock,
  input  logic                                               reset_n,
  input  logic                                               write_enable,
  input  logic [TIA_NUM_OUTPUT_CHANNELS-1:0]                 oci,
  input  logic [TIA_TAG_WIDTH-1:0]                           output_tag,
  input  logic [TIA_WORD_WIDTH-1:0]                          output_data,
  output logic [TIA_NUM_OUTPUT_CHANNELS-1:0]                 output_channel_full_status,
  output logic [TIA_NUM_OUTPUT_CHANNELS-1:0]                 output_channel_valids,
  input  logic [TIA_NUM_OUTPUT_CHANNELS-1:0]                 output_channel_readys,
  output logic [TIA_NUM_OUTPUT_CHANNELS*TIA_TAG_WIDTH-1:0]   output_channel_tags,
  output logic [TIA_NUM_OUTPUT_CHANNELS*TIA_WORD_WIDTH-1:0]  output_channel_data,
  output logic                                               overflow_error
);
  localparam int N = TIA_NUM_OUTPUT_CHANNELS;
  localparam int TW = TIA_TAG_WIDTH;
  localparam int WW = TIA_WORD_WIDTH;
  localparam int D = TIA_OUTPUT_CHANNEL_BUFFER_DEPTH;
  localparam int AW = $clog2(D);
  logic          write_req;
  logic          blocked;
  logic [N-1:0]  push;
  logic [N-1:0]  pop;
  assign write_req = write_enable && (oci != '0);
  // full is taken from the registered count, so a same-cycle pop never frees room for a write
  assign blocked = write_req && ((oci & output_channel_full_status) != '0);
  assign push = (write_req && !blocked) ? oci : '0;
  assign pop = output_channel_valids & output_channel_readys;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) overflow_error <= 1'b0;
    else if (blocked) overflow_error <= 1'b1;
  for (genvar i = 0; i < N; i++) begin : g_ch
    logic [TW+WW-1:0] mem [D];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [AW:0]      count;
    assign output_channel_full_status[i] = (count == (AW+1)'(D));
    assign output_channel_valids[i] = (count != '0);
    assign output_channel_tags[i*TW +: TW] = mem[rd_ptr][WW +: TW];
    assign output_channel_data[i*WW +: WW] = mem[rd_ptr][WW-1:0];
    always_ff @(posedge clock)
      if (push[i]) mem[wr_ptr] <= {output_tag, output_data};
    always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count <= '0;
      end else begin
        if (push[i]) wr_ptr <= wr_ptr + AW'(1);
        if (pop[i]) rd_ptr <= rd_ptr + AW'(1);
        if (push[i] != pop[i]) count <= push[i] ? count + (AW+1)'(1) : count - (AW+1)'(1);
      end
  end
endmodule

// File: tb/tb_output_channel_buffer_bank.sv
// tb_output_channel_buffer_bank: directed table-driven checks plus streaming and async-reset sequences
module tb_output_channel_buffer_bank;
  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        write_enable = 1'b0;
  logic [3:0]  oci = '0;
  logic [1:0]  output_tag = '0;
  logic [31:0] output_data = '0;
  logic [3:0]  output_channel_full_status;
  logic [3:0]  output_channel_valids;
  logic [3:0]  output_channel_readys = '0;
  logic [7:0]  output_channel_tags;
  logic [127:0] output_channel_data;
  logic        overflow_error;
  int          n_checks = 0;
  int          n_fail = 0;

  output_channel_buffer_bank dut (
    .clock(clock),
    .reset_n(reset_n),
    .write_enable(write_enable),
    .oci(oci),
    .output_tag(output_tag),
    .output_data(output_data),
    .output_channel_full_status(output_channel_full_status),
    .output_channel_valids(output_channel_valids),
    .output_channel_readys(output_channel_readys),
    .output_channel_tags(output_channel_tags),
    .output_channel_data(output_channel_data),
    .overflow_error(overflow_error)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        rst;
    logic        we;
    logic [3:0]  oci;
    logic [1:0]  tag;
    logic [31:0] data;
    logic [3:0]  rdy;
    logic [3:0]  ev;
    logic [3:0]  ef;
    logic        eo;
    int          ch;
    logic [1:0]  et;
    logic [31:0] ed;
  } vec_t;

  vec_t v[22];

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    write_enable = 1'b0;
    oci = '0;
    output_channel_readys = '0;
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic drive(input logic we, input logic [3:0] o, input logic [1:0] t, input logic [31:0] d, input logic [3:0] r);
    @(negedge clock);
    write_enable = we;
    oci = o;
    output_tag = t;
    output_data = d;
    output_channel_readys = r;
    @(posedge clock);
    #1;
  endtask

  initial begin
    v[0]  = '{1, 1, 4'b0010, 2'd1, 32'hDEADBEEF, 4'b0000, 4'b0010, 4'b0000, 0, 1, 2'd1, 32'hDEADBEEF};
    v[1]  = '{0, 0, 4'b0000, 2'd0, 32'h0,        4'b0010, 4'b0000, 4'b0000, 0, -1, 2'd0, 32'h0};
    v[2]  = '{0, 1, 4'b0001, 2'd0, 32'hA0,       4'b0000, 4'b0001, 4'b0000, 0, 0, 2'd0, 32'hA0};
    v[3]  = '{0, 1, 4'b0001, 2'd2, 32'hA1,       4'b0000, 4'b0001, 4'b0001, 0, 0, 2'd0, 32'hA0};
    v[4]  = '{0, 1, 4'b0001, 2'd3, 32'hA2,       4'b0000, 4'b0001, 4'b0001, 1, 0, 2'd0, 32'hA0};
    v[5]  = '{0, 0, 4'b0000, 2'd0, 32'h0,        4'b0001, 4'b0001, 4'b0000, 1, 0, 2'd2, 32'hA1};
    v[6]  = '{0, 0, 4'b0000, 2'd0, 32'h0,        4'b0001, 4'b0000, 4'b0000, 1, -1, 2'd0, 32'h0};
    v[7]  = '{1, 1, 4'b1000, 2'd1, 32'hB0,       4'b0000, 4'b1000, 4'b0000, 0, 3, 2'd1, 32'hB0};
    v[8]  = '{0, 1, 4'b1000, 2'd1, 32'hB1,       4'b0000, 4'b1000, 4'b1000, 0, 3, 2'd1, 32'hB0};
    v[9]  = '{0, 1, 4'b1011, 2'd2, 32'hC0,       4'b0000, 4'b1000, 4'b1000, 1, 3, 2'd1, 32'hB0};
    v[10] = '{0, 0, 4'b0000, 2'd0, 32'h0,        4'b1000, 4'b1000, 4'b0000, 1, 3, 2'd1, 32'hB1};
    v[11] = '{0, 1, 4'b1011, 2'd2, 32'hC0,       4'b0000, 4'b1011, 4'b1000, 1, 0, 2'd2, 32'hC0};
    v[12] = '{0, 0, 4'b0000, 2'd0, 32'h0,        4'b0001, 4'b1010, 4'b1000, 1, 1, 2'd2, 32'hC0};
    v[13] = '{0, 0, 4'b0000, 2'd0, 32'h0,        4'b1010, 4'b1000, 4'b0000, 1, 3, 2'd2, 32'hC0};
    v[14] = '{1, 1, 4'b0100, 2'd0, 32'hD0,       4'b0000, 4'b0100, 4'b0000, 0, 2, 2'd0, 32'hD0};
    v[15] = '{0, 1, 4'b0100, 2'd1, 32'hD1,       4'b0000, 4'b0100, 4'b0100, 0, 2, 2'd0, 32'hD0};
    v[16] = '{0, 1, 4'b0100, 2'd2, 32'hD2,       4'b0100, 4'b0100, 4'b0000, 1, 2, 2'd1, 32'hD1};
    v[17] = '{0, 0, 4'b0000, 2'd0, 32'h0,        4'b0100, 4'b0000, 4'b0000, 1, -1, 2'd0, 32'h0};
    v[18] = '{1, 1, 4'b0000, 2'd3, 32'hFF,       4'b0000, 4'b0000, 4'b0000, 0, -1, 2'd0, 32'h0};
    v[19] = '{0, 1, 4'b0001, 2'd0, 32'hE0,       4'b0000, 4'b0001, 4'b0000, 0, 0, 2'd0, 32'hE0};
    v[20] = '{0, 1, 4'b0001, 2'd1, 32'hE1,       4'b0001, 4'b0001, 4'b0000, 0, 0, 2'd1, 32'hE1};
    v[21] = '{0, 0, 4'b0000, 2'd0, 32'h0,        4'b0001, 4'b0000, 4'b0000, 0, -1, 2'd0, 32'h0};
    #1;
    chk("reset_valids", -1, 32'(output_channel_valids), 32'h0);
    chk("reset_full", -1, 32'(output_channel_full_status), 32'h0);
    chk("reset_ovf", -1, 32'(overflow_error), 32'h0);
    @(negedge clock);
    reset_n = 1'b1;
    for (int k = 0; k < 22; k++) begin
      if (v[k].rst) do_reset();
      drive(v[k].we, v[k].oci, v[k].tag, v[k].data, v[k].rdy);
      chk("valids", k, 32'(output_channel_valids), 32'(v[k].ev));
      chk("full", k, 32'(output_channel_full_status), 32'(v[k].ef));
      chk("overflow", k, 32'(overflow_error), 32'(v[k].eo));
      if (v[k].ch >= 0) begin
        chk("head_data", k, output_channel_data[v[k].ch*32 +: 32], v[k].ed);
        chk("head_tag", k, 32'(output_channel_tags[v[k].ch*2 +: 2]), 32'(v[k].et));
      end
    end
    do_reset();
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 4'b0001, 2'(k), 32'(k), 4'b0001);
      chk("stream_valid", k, 32'(output_channel_valids), 32'h1);
      chk("stream_head", k, output_channel_data[31:0], 32'(k));
      chk("stream_full", k, 32'(output_channel_full_status), 32'h0);
      chk("stream_ovf", k, 32'(overflow_error), 32'h0);
    end
    drive(1'b0, 4'b0000, 2'd0, 32'h0, 4'b0001);
    chk("stream_drain", 10, 32'(output_channel_valids), 32'h0);
    do_reset();
    drive(1'b1, 4'b0010, 2'd1, 32'h11, 4'b0000);
    drive(1'b1, 4'b0010, 2'd1, 32'h22, 4'b0000);
    drive(1'b1, 4'b0010, 2'd1, 32'h33, 4'b0000);
    chk("pre_arst_full", 0, 32'(output_channel_full_status), 32'h2);
    chk("pre_arst_ovf", 0, 32'(overflow_error), 32'h1);
    #2;
    reset_n = 1'b0;
    write_enable = 1'b0;
    #1;
    chk("arst_valids", 0, 32'(output_channel_valids), 32'h0);
    chk("arst_full", 0, 32'(output_channel_full_status), 32'h0);
    chk("arst_ovf", 0, 32'(overflow_error), 32'h0);
    @(negedge clock);
    reset_n = 1'b1;
    drive(1'b1, 4'b0010, 2'd2, 32'h44, 4'b0000);
    chk("post_arst_valids", 0, 32'(output_channel_valids), 32'h2);
    chk("post_arst_head", 0, output_channel_data[63:32], 32'h44);
    chk("post_arst_full", 0, 32'(output_channel_full_status), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/output_channel_buffer_bank.md
# output_channel_buffer_bank

Bank of per-channel output FIFOs between the PE's writeback stage and the interconnect. Each cycle the bank accepts one result word and tag. It broadcasts them into every output channel selected by the output channel indicator (OCI). It drains each channel independently over a valid/ready link. Its registered per-channel full vector is the `output_channel_full_status` consumed by the pessimistic full-status updater ahead of the trigger resolver.

## Interface

Parameters:
- TIA_NUM_OUTPUT_CHANNELS, 4: number of output channels; also the OCI width.
- TIA_WORD_WIDTH, 32: data word width.
- TIA_TAG_WIDTH, 2: tag width.
- TIA_OUTPUT_CHANNEL_BUFFER_DEPTH, 2: entries per channel; power of two, ≥ 2.

Ports:
- clock  input  1  sole clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- write_enable  input  1  writeback stage has a retiring instruction.
- oci  input  TIA_NUM_OUTPUT_CHANNELS  destination channel mask; multiple bits set = multicast.
- output_tag  input  TIA_TAG_WIDTH  tag to enqueue.
- output_data  input  TIA_WORD_WIDTH  word to enqueue.
- output_channel_full_status  output  TIA_NUM_OUTPUT_CHANNELS  bit i set when channel i holds DEPTH entries.
- output_channel_valids  output  TIA_NUM_OUTPUT_CHANNELS  channel i head entry present.
- output_channel_readys  input  TIA_NUM_OUTPUT_CHANNELS  downstream accepts channel i head.
- output_channel_tags  output  NUM×TAG  flattened head tags; channel i at [i*TAG +: TAG].
- output_channel_data  output  NUM×WORD  flattened head words; channel i at [i*WORD +: WORD].
- overflow_error  output  1  sticky: a write targeted a full channel.

## Operation

- Per channel: circular buffer, read/write pointers log2(DEPTH) bits, count log2(DEPTH)+1 bits.
- Write qualifies when write_enable=1 and oci≠0.
- Atomic multicast: the write is accepted only if no selected channel is full. It then enqueues {tag, data} into every selected channel. If any selected channel is full, no channel is written and overflow_error is set.
- write_enable=1 with oci=0: no-op, no error.
- Pop on channel i when output_channel_valids[i] & output_channel_readys[i]: read pointer increments mod DEPTH, count decrements.
- Same-cycle push and pop on one channel: count unchanged, both pointers advance.
- Full is evaluated against the registered count, so a full channel rejects a write even if it pops in the same cycle. The updater depends on this conservative behaviour.
- output_channel_valids[i] = (count_i ≠ 0). Head data/tag come combinationally from storage[read pointer]. They are held stable while valid and not ready.
- Pointer wrap: DEPTH−1 → 0; count never exceeds DEPTH or underflows. Pops are gated by valid.
- overflow_error is cleared only by reset.

## Timing

- Reset (reset_n=0, asynchronous): all pointers and counts 0. output_channel_valids=0, output_channel_full_status=0, overflow_error=0. Storage is not reset; head data/tag are don't-care while invalid.
- Reset asserted mid-operation discards all queued entries immediately. There is no partial-pop behaviour.
- Write at edge t: the entry is visible (valid=1) from cycle t+1. A pop is possible at edge t+1 at the earliest. Write-to-downstream latency is 1 cycle.
- Full status updates at the same edge as the causing push/pop. Bit i rises the cycle after the DEPTH-th outstanding push and falls the cycle after a pop from full.
- Throughput: one push and one pop per channel per cycle; sustained 1 word/cycle for DEPTH ≥ 2.
- overflow_error rises the cycle after the rejected write.

## Test plan

- Reset then single write, oci=4'b0010, data=0xDEADBEEF, tag=1 -> cycle+1: valids=4'b0010, channel 1 head=0xDEADBEEF/tag 1. Full stays 0 (DEPTH=2). Ready on ch1 -> valids=0 next cycle.
- Fill ch0: two writes with readys=0 -> full_status=4'b0001 after the second. A third write to ch0 -> dropped, overflow_error=1, count stays 2, head still the first word.
- Multicast oci=4'b1011 with ch3 full -> no channel written (ch0/ch1 counts unchanged), overflow_error=1. Same write with ch3 not full -> all three valids set with identical data.
- Full ch2 with ready=1 and a write to ch2 in the same cycle -> write rejected, overflow_error=1, count drops to 1.
- Streaming on ch0 with ready=1 every cycle, 10 writes 0..9 -> output order 0..9, count never exceeds 1, no overflow, pointers wrap correctly.
- reset_n pulsed low asynchronously mid-stream (between edges) with entries queued -> valids, full_status and overflow_error go 0 immediately. The first write after release appears one cycle later.
